msdap_frame_sched: RTL and testbench
====================================

Name: msdap_frame_sched

Overview:
- Front-end controller for the stereo audio datapath.
- Deserialises the 2-bit serial stereo input (bit 0 = left, bit 1 = right) into 16-bit left/right sample words, framed by Frame.
- Schedules the shared filter core: each captured pair is presented as left then right over a single valid/ready port.
- Sits between the serial input pins and the shared compute core. Runs entirely in the Sclk domain; bit_en is a pre-synchronised one-cycle Dclk strobe.

Parameters:
- DATA_W, 16, sample word width in bits (MSB first on the serial input).
- SLEEP_CNT, 800, consecutive all-zero frames before sleep (used only with MSDAP_SLEEP_EN).

Ports:
- Sclk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Start  input  1  level; 1 enables capture.
- bit_en  input  1  one-cycle strobe; the serial bits are valid this cycle.
- Frame  input  1  qualified by bit_en; marks the MSB bit of a new frame.
- in  input  2  serial data; in[0] = left bit, in[1] = right bit.
- out_data  output  DATA_W  sample word to the core.
- out_ch  output  1  0 = left, 1 = right.
- out_valid  output  1  sample offered.
- out_ready  input  1  core accepts; transfer occurs on out_valid && out_ready.
- busy  output  1  capture in progress or pair pending.
- overrun  output  1  sticky; a pair was dropped.
- frame_err  output  1  sticky; Frame arrived mid-word.
- sleep  output  1  sleep mode active.

Behaviour:
- Reset (Reset_n = 0 at an edge):
  - Both FSMs go to their idle state; counters and holding registers are cleared.
  - out_data = 0, out_ch = 0, out_valid = 0, busy = 0, overrun = 0, frame_err = 0, sleep = 0.
  - Reset in mid-capture or mid-dispatch drops everything with no partial output.
- Capture FSM (C_IDLE, C_WAIT, C_SHIFT):
  - C_IDLE: Start = 1 -> C_WAIT.
  - C_WAIT: bit_en && Frame loads in[0] and in[1] as MSBs, sets bit_cnt = 1, then -> C_SHIFT. bit_en without Frame is ignored.
  - C_SHIFT: each bit_en shifts {L,R} left and increments bit_cnt.
    - At the edge that samples bit DATA_W: load the pair into the holding registers, set pending, return to C_WAIT.
    - bit_en && Frame while bit_cnt < DATA_W: set frame_err, discard the partial word, treat this bit as a new MSB with bit_cnt = 1.
  - Start = 0 in any state -> C_IDLE at the next edge; the partial word is discarded.
- Dispatch FSM (D_IDLE, D_LEFT, D_RIGHT):
  - D_IDLE with pending -> D_LEFT.
  - D_LEFT: out_valid = 1, out_ch = 0, out_data = L; on transfer -> D_RIGHT.
  - D_RIGHT: out_ch = 1, out_data = R; on transfer -> D_IDLE and clear pending.
  - out_valid rises exactly one cycle after the edge that captured bit DATA_W. Minimum 2 cycles per pair when out_ready is held at 1.
  - out_data and out_ch are held stable while out_valid && !out_ready. out_valid never drops without a transfer, except on reset.
  - Start = 0 does not abort dispatch of an already latched pair.
  - out_data and out_ch are don't-care when out_valid = 0 (implementation drives 0).
- Overrun:
  - If a pair completes while pending = 1, the new pair is dropped and overrun is set. The held pair is unaffected.
  - If the completion edge coincides with the final R transfer, the new pair is accepted and no overrun occurs.
- busy = (capture state is C_SHIFT) || pending.
- Sticky flags clear only on reset.

Optional Feature:
- Macro MSDAP_SLEEP_EN.
- When defined:
  - A counter tracks consecutive completed pairs with L == 0 and R == 0, saturating at SLEEP_CNT.
  - When it reaches SLEEP_CNT, sleep = 1 on the next edge, and zero pairs are no longer dispatched (pending is not set).
  - The first pair with a non-zero word clears sleep and the counter in the same edge and is dispatched normally.
  - Zero pairs below the threshold are dispatched.
- When undefined: sleep is tied to 0, no counter is instantiated, and every pair is dispatched.

Test Plan:
- Reset, then Start = 1, one frame with L = 0xA5C3, R = 0x1234, out_ready = 1 -> out_valid rises 1 cycle after the bit-16 edge; transfers (ch 0, 0xA5C3) then (ch 1, 0x1234); overrun = 0, frame_err = 0.
- Same frame with out_ready = 0 for 10 cycles -> out_valid = 1 with ch 0 and 0xA5C3 held stable for 10 cycles, then both transfers.
- Frame re-asserted at bit 9, then a full word 0x00FF/0xFF00 -> frame_err = 1; only 0x00FF/0xFF00 dispatched.
- out_ready held at 0 across two complete frames (0x1111/0x2222, then 0x3333/0x4444) -> overrun = 1; only 0x1111/0x2222 dispatched after out_ready rises.
- Start = 0 at bit 5 -> no output, busy = 0 next cycle; Reset_n = 0 during D_RIGHT -> out_valid = 0 next edge, all flags 0.
- MSDAP_SLEEP_EN, SLEEP_CNT = 4: 4 zero frames (dispatched), then sleep = 1; a 5th zero frame is not dispatched; frame 0x0001/0x0000 -> sleep = 0 and that pair is dispatched.

Source files
------------

// File: rtl/msdap_frame_sched.sv
// msdap_frame_sched: serial stereo deserialiser and left/right scheduler
// for the shared filter core.
//
// Ports:
//   Sclk, Reset_n (sync, active low)
//   Start  : level enable for capture
//   bit_en : one-cycle strobe qualifying Frame and in
//   Frame  : marks the MSB bit of a new frame
//   in     : serial bits, in[0] = left, in[1] = right
//   out_*  : valid/ready sample port, left word then right word
//   busy, overrun (sticky), frame_err (sticky), sleep
//
// Optional build macro: MSDAP_SLEEP_EN. When defined, a run of SLEEP_CNT
// all-zero pairs enters sleep and later zero pairs are not dispatched.
// When undefined, sleep is tied low.
module msdap_frame_sched #(
  parameter int DATA_W    = 16,
  parameter int SLEEP_CNT = 800
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              bit_en,
  input  logic              Frame,
  input  logic [1:0]        in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  output logic              sleep
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_SHIFT
  } cstate_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LEFT,
    D_RIGHT
  } dstate_t;

  cstate_t r_cstate, w_cnext;
  dstate_t r_dstate, w_dnext;

  // Only DATA_W-1 bits are kept: the last bit is merged straight
  // into the holding register at completion.
  logic [DATA_W-2:0] r_sh_l, r_sh_r;
  logic [DATA_W-2:0] w_sh_l_nx, w_sh_r_nx;
  logic [CW-1:0]     r_bit_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic              r_pending;
  logic              r_overrun, r_frame_err;

  logic              w_done, w_ferr;
  logic [DATA_W-1:0] w_new_l, w_new_r;
  logic              w_r_done, w_accept, w_want, w_sup;

  assign w_new_l = {r_sh_l, in[0]};
  assign w_new_r = {r_sh_r, in[1]};

  always_comb begin
    w_cnext   = r_cstate;
    w_sh_l_nx = r_sh_l;
    w_sh_r_nx = r_sh_r;
    w_cnt_nx  = r_bit_cnt;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    if (!Start) begin
      w_cnext   = C_IDLE;
      w_cnt_nx  = '0;
      w_sh_l_nx = '0;
      w_sh_r_nx = '0;
    end else begin
      unique case (r_cstate)
        C_IDLE: w_cnext = C_WAIT;
        C_WAIT: begin
          if (bit_en && Frame) begin
            w_sh_l_nx = {{(DATA_W-2){1'b0}}, in[0]};
            w_sh_r_nx = {{(DATA_W-2){1'b0}}, in[1]};
            w_cnt_nx  = CW'(1);
            w_cnext   = C_SHIFT;
          end
        end
        C_SHIFT: begin
          if (bit_en) begin
            if (Frame) begin
              // Early frame: drop the partial word, restart on this bit.
              w_ferr    = 1'b1;
              w_sh_l_nx = {{(DATA_W-2){1'b0}}, in[0]};
              w_sh_r_nx = {{(DATA_W-2){1'b0}}, in[1]};
              w_cnt_nx  = CW'(1);
            end else if (r_bit_cnt == CW'(DATA_W - 1)) begin
              w_done   = 1'b1;
              w_cnt_nx = '0;
              w_cnext  = C_WAIT;
            end else begin
              w_sh_l_nx = {r_sh_l[DATA_W-3:0], in[0]};
              w_sh_r_nx = {r_sh_r[DATA_W-3:0], in[1]};
              w_cnt_nx  = r_bit_cnt + CW'(1);
            end
          end
        end
        default: w_cnext = C_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dnext = r_dstate;
    unique case (r_dstate)
      D_IDLE:  if (r_pending) w_dnext = D_LEFT;
      D_LEFT:  if (out_ready) w_dnext = D_RIGHT;
      D_RIGHT: if (out_ready) w_dnext = D_IDLE;
      default: w_dnext = D_IDLE;
    endcase
  end

  // A pair finishing on the same edge as the final right transfer
  // may take the freed holding slot.
  assign w_r_done = (r_dstate == D_RIGHT) && out_ready;
  assign w_accept = !r_pending || w_r_done;
  assign w_want   = w_done && !w_sup;

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      r_cstate    <= C_IDLE;
      r_dstate    <= D_IDLE;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      r_bit_cnt   <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cstate  <= w_cnext;
      r_dstate  <= w_dnext;
      r_sh_l    <= w_sh_l_nx;
      r_sh_r    <= w_sh_r_nx;
      r_bit_cnt <= w_cnt_nx;
      if (w_want && w_accept) begin
        r_hold_l  <= w_new_l;
        r_hold_r  <= w_new_r;
        r_pending <= 1'b1;
      end else if (w_r_done) begin
        r_pending <= 1'b0;
      end
      if (w_want && !w_accept) r_overrun <= 1'b1;
      if (w_ferr) r_frame_err <= 1'b1;
    end
  end

`ifdef MSDAP_SLEEP_EN
  localparam int ZW = $clog2(SLEEP_CNT + 1);

  logic [ZW-1:0] r_zcnt;
  logic          r_sleep;
  logic          w_zero;

  assign w_zero = (w_new_l == '0) && (w_new_r == '0);
  assign w_sup  = r_sleep && w_zero;

  always_ff @(posedge Sclk) begin
    if (!Reset_n) begin
      r_zcnt  <= '0;
      r_sleep <= 1'b0;
    end else if (w_done && !w_zero) begin
      r_zcnt  <= '0;
      r_sleep <= 1'b0;
    end else begin
      if (w_done && r_zcnt != ZW'(SLEEP_CNT)) r_zcnt <= r_zcnt + ZW'(1);
      if (r_zcnt == ZW'(SLEEP_CNT)) r_sleep <= 1'b1;
    end
  end

  assign sleep = r_sleep;
`else
  logic w_unused_sleep_cnt;
  assign w_unused_sleep_cnt = (SLEEP_CNT != 0);
  assign w_sup = 1'b0;
  assign sleep = 1'b0;
`endif

  assign out_valid = (r_dstate != D_IDLE);
  assign out_ch    = (r_dstate == D_RIGHT);
  assign out_data  = (r_dstate == D_LEFT)  ? r_hold_l :
                     (r_dstate == D_RIGHT) ? r_hold_r : '0;
  assign busy      = (r_cstate == C_SHIFT) || r_pending;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_msdap_frame_sched.sv
// tb_msdap_frame_sched: directed bench for msdap_frame_sched.
// Expected pairs go to a queue; a forked monitor checks each transfer.
module tb_msdap_frame_sched;

  logic        Sclk = 0;
  logic        Reset_n = 0;
  logic        Start = 0;
  logic        bit_en = 0;
  logic        Frame = 0;
  logic [1:0]  in = 0;
  logic [15:0] out_data;
  logic        out_ch;
  logic        out_valid;
  logic        out_ready = 0;
  logic        busy, overrun, frame_err, sleep;

  int n_chk = 0;
  int n_fail = 0;
  logic [16:0] sb[$];

  msdap_frame_sched #(.DATA_W(16), .SLEEP_CNT(4)) dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .Start(Start),
    .bit_en(bit_en), .Frame(Frame), .in(in),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun),
    .frame_err(frame_err), .sleep(sleep)
  );

  always #5 Sclk = ~Sclk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Sclk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    sb.push_back({1'b0, l});
    sb.push_back({1'b1, r});
  endtask

  // Sends the n MSBs of l/r, Frame on the first, one idle cycle
  // between strobes; returns #1 after the last strobe edge.
  task automatic send_bits(input logic [15:0] l,
                           input logic [15:0] r,
                           input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) cyc();
      bit_en = 1;
      Frame  = (i == 0);
      in     = {r[15-i], l[15-i]};
      cyc();
      bit_en = 0;
      Frame  = 0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !out_valid && !busy) break;
      cyc();
    end
    chk("drain", {31'd0, sb.size() == 0 && !out_valid}, 32'd1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge Sclk);
        if (Reset_n && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_xfer", {15'd0, out_ch, out_data}, 32'h1ffff);
          end else begin
            chk("xfer", {15'd0, out_ch, out_data}, {15'd0, sb.pop_front()});
          end
        end
      end
    join_none

    // reset state
    repeat (3) cyc();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {16'd0, out_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_flags", {29'd0, overrun, frame_err, sleep}, 0);
    Reset_n = 1;
    Start = 1;
    out_ready = 1;
    cyc();

    // basic frame, valid one cycle after the completion edge
    push(16'hA5C3, 16'h1234);
    send_bits(16'hA5C3, 16'h1234, 16);
    chk("lat_valid_lo", {31'd0, out_valid}, 0);
    chk("lat_busy", {31'd0, busy}, 1);
    cyc();
    chk("lat_valid_hi", {31'd0, out_valid}, 1);
    chk("lat_first", {15'd0, out_ch, out_data}, {15'd0, 17'h0A5C3});
    wait_drain();
    chk("t1_flags", {30'd0, overrun, frame_err}, 0);

    // back-pressure hold for 10 cycles
    out_ready = 0;
    push(16'hA5C3, 16'h1234);
    send_bits(16'hA5C3, 16'h1234, 16);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("hold", {14'd0, out_valid, out_ch, out_data}, {14'd0, 18'h2A5C3});
      cyc();
    end
    out_ready = 1;
    wait_drain();

    // early Frame at bit 9
    chk("ferr_pre", {31'd0, frame_err}, 0);
    send_bits(16'hDEAD, 16'hBEEF, 8);
    cyc();
    push(16'h00FF, 16'hFF00);
    send_bits(16'h00FF, 16'hFF00, 16);
    chk("ferr_set", {31'd0, frame_err}, 1);
    wait_drain();

    // overrun with two frames while stalled
    out_ready = 0;
    push(16'h1111, 16'h2222);
    send_bits(16'h1111, 16'h2222, 16);
    cyc();
    chk("ovr_pre", {31'd0, overrun}, 0);
    send_bits(16'h3333, 16'h4444, 16);
    chk("ovr_set", {31'd0, overrun}, 1);
    chk("ovr_held", {16'd0, out_data}, 32'h1111);
    out_ready = 1;
    wait_drain();

    // Start drops at bit 5
    send_bits(16'h5555, 16'hAAAA, 4);
    cyc();
    bit_en = 1;
    in = 2'b11;
    Start = 0;
    cyc();
    bit_en = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (10) cyc();
    chk("abort_valid", {31'd0, out_valid}, 0);
    Start = 1;
    cyc();

    // reset during right-channel offer
    out_ready = 0;
    sb.push_back({1'b0, 16'hBEEF});
    send_bits(16'hBEEF, 16'hCAFE, 16);
    cyc();
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("dright", {14'd0, out_valid, out_ch, out_data}, {14'd0, 18'h3CAFE});
    Reset_n = 0;
    cyc();
    chk("rst2_valid", {31'd0, out_valid}, 0);
    chk("rst2_flags", {28'd0, busy, overrun, frame_err, sleep}, 0);
    Reset_n = 1;
    out_ready = 1;
    cyc();
    chk("rst2_sb", sb.size(), 0);

`ifdef MSDAP_SLEEP_EN
    for (int k = 0; k < 4; k++) begin
      push(16'h0000, 16'h0000);
      send_bits(16'h0000, 16'h0000, 16);
      cyc();
      wait_drain();
    end
    chk("sleep_on", {31'd0, sleep}, 1);
    send_bits(16'h0000, 16'h0000, 16);
    repeat (6) cyc();
    chk("sleep_drop", {30'd0, out_valid, busy}, 0);
    push(16'h0001, 16'h0000);
    send_bits(16'h0001, 16'h0000, 16);
    chk("sleep_off", {31'd0, sleep}, 0);
    wait_drain();
`else
    for (int k = 0; k < 5; k++) begin
      push(16'h0000, 16'h0000);
      send_bits(16'h0000, 16'h0000, 16);
      cyc();
      wait_drain();
    end
    chk("sleep_tied", {31'd0, sleep}, 0);
`endif

    repeat (4) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
